// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl
// Purpose: instruction-fetch sequencer for a 64-entry, 32-bit instruction
// memory with a combinational read. Owns the PC, drives the memory
// address, registers fetched words as the issued instruction, stops on a
// halt word and lends the single read port to a debug requester whenever
// the issue stage does not need it.
//
// Ports:
//   i_clk          rising-edge clock
//   i_rst_n        asynchronous active-low reset
//   i_start        begin fetching at RESET_PC (used in IDLE and HALT)
//   i_stall        freeze the issue stage (PC, instruction, valid)
//   i_br_taken     redirect PC to i_br_target, squashing this cycle
//   i_br_target    redirect word address
//   o_a            memory address (combinational: debug or PC)
//   i_rd           memory read data for o_a, same cycle
//   o_instr        registered issued instruction
//   o_instr_pc     address o_instr came from
//   o_instr_valid  o_instr is live this cycle
//   o_halted       sequencer is in HALT
//   i_dbg_req      debug read request (level)
//   i_dbg_addr     debug read address
//   o_dbg_ack      one-cycle pulse, o_dbg_data valid
//   o_dbg_data     registered debug read data
//   o_instr_count  saturating count of issued instructions
module imem_fetch_ctrl #(
  parameter int          AW         = 6,
  parameter int          DW         = 32,
  parameter int          RESET_PC   = 0,
  parameter logic [31:0] HALT_INSTR = 32'hFFFF_FFFF,
  parameter int          CW         = 16
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_start,
  input  logic          i_stall,
  input  logic          i_br_taken,
  input  logic [AW-1:0] i_br_target,
  output logic [AW-1:0] o_a,
  input  logic [DW-1:0] i_rd,
  output logic [DW-1:0] o_instr,
  output logic [AW-1:0] o_instr_pc,
  output logic          o_instr_valid,
  output logic          o_halted,
  input  logic          i_dbg_req,
  input  logic [AW-1:0] i_dbg_addr,
  output logic          o_dbg_ack,
  output logic [DW-1:0] o_dbg_data,
  output logic [CW-1:0] o_instr_count
);

  localparam logic [AW-1:0] W_RESET_PC = AW'(RESET_PC);
  localparam logic [DW-1:0] W_HALT     = DW'(HALT_INSTR);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t        r_state,  w_state_next;
  logic [AW-1:0] r_pc,     w_pc_next;
  logic [DW-1:0] r_instr,  w_instr_next;
  logic [AW-1:0] r_ipc,    w_ipc_next;
  logic          r_valid,  w_valid_next;
  logic          r_halted, w_halted_next;
  logic          r_ack,    w_ack_next;
  logic [DW-1:0] r_ddata,  w_ddata_next;
  logic [CW-1:0] r_count,  w_count_next;
  logic          w_grant;

  // The port is free for debug outside RUN, or in RUN when the issue stage
  // is stalled and not being redirected. Blocking on r_ack spaces grants so
  // each request level produces one read per ack.
  assign w_grant = i_dbg_req && !r_ack &&
                   ((r_state != ST_RUN) || (i_stall && !i_br_taken));

  assign o_a = w_grant ? i_dbg_addr : r_pc;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= ST_IDLE;
      r_pc     <= W_RESET_PC;
      r_instr  <= '0;
      r_ipc    <= '0;
      r_valid  <= 1'b0;
      r_halted <= 1'b0;
      r_ack    <= 1'b0;
      r_ddata  <= '0;
      r_count  <= '0;
    end else begin
      r_state  <= w_state_next;
      r_pc     <= w_pc_next;
      r_instr  <= w_instr_next;
      r_ipc    <= w_ipc_next;
      r_valid  <= w_valid_next;
      r_halted <= w_halted_next;
      r_ack    <= w_ack_next;
      r_ddata  <= w_ddata_next;
      r_count  <= w_count_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_pc_next     = r_pc;
    w_instr_next  = r_instr;
    w_ipc_next    = r_ipc;
    w_valid_next  = r_valid;
    w_halted_next = r_halted;
    w_ack_next    = w_grant;
    w_ddata_next  = w_grant ? i_rd : r_ddata;
    w_count_next  = r_count;

    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_pc_next    = W_RESET_PC;
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (i_br_taken) begin
          w_pc_next    = i_br_target;
          w_valid_next = 1'b0;
        end else if (i_stall) begin
          // hold everything; a debug read may use the port meanwhile
        end else if (i_rd == W_HALT) begin
          // halt word is not issued; PC parks on it
          w_valid_next  = 1'b0;
          w_halted_next = 1'b1;
          w_state_next  = ST_HALT;
        end else begin
          w_instr_next = i_rd;
          w_ipc_next   = r_pc;
          w_valid_next = 1'b1;
          w_pc_next    = r_pc + 1'b1;
          if (r_count != '1) begin
            w_count_next = r_count + 1'b1;
          end
        end
      end
      ST_HALT: begin
        w_valid_next = 1'b0;
        if (i_start) begin
          w_pc_next     = W_RESET_PC;
          w_halted_next = 1'b0;
          w_state_next  = ST_RUN;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  assign o_instr       = r_instr;
  assign o_instr_pc    = r_ipc;
  assign o_instr_valid = r_valid;
  assign o_halted      = r_halted;
  assign o_dbg_ack     = r_ack;
  assign o_dbg_data    = r_ddata;
  assign o_instr_count = r_count;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb_imem_fetch_ctrl
// Purpose: directed-vector bench for imem_fetch_ctrl with a behavioural
// combinational-read instruction memory. Expected values are hand-computed.
module tb_imem_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, stall, br_taken, dbg_req;
  logic [5:0]  br_target, dbg_addr, a;
  logic [31:0] rd, instr, dbg_data;
  logic [5:0]  instr_pc;
  logic        instr_valid, halted, dbg_ack;
  logic [15:0] instr_count;

  logic [31:0] mem [64];
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign rd = mem[a];

  imem_fetch_ctrl dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_start       (start),
    .i_stall       (stall),
    .i_br_taken    (br_taken),
    .i_br_target   (br_target),
    .o_a           (a),
    .i_rd          (rd),
    .o_instr       (instr),
    .o_instr_pc    (instr_pc),
    .o_instr_valid (instr_valid),
    .o_halted      (halted),
    .i_dbg_req     (dbg_req),
    .i_dbg_addr    (dbg_addr),
    .o_dbg_ack     (dbg_ack),
    .o_dbg_data    (dbg_data),
    .o_instr_count (instr_count)
  );

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue-stage snapshot in one call.
  task automatic check_issue(input string tag, input logic [31:0] e_instr,
                             input logic [5:0] e_pc, input logic e_valid,
                             input logic [15:0] e_cnt);
    check_val({tag, ".instr"}, instr, e_instr);
    check_val({tag, ".ipc"},   {26'd0, instr_pc}, {26'd0, e_pc});
    check_val({tag, ".valid"}, {31'd0, instr_valid}, {31'd0, e_valid});
    check_val({tag, ".count"}, {16'd0, instr_count}, {16'd0, e_cnt});
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 + i;
    mem[0] = 32'd11; mem[1] = 32'd22; mem[2] = 32'd33; mem[3] = 32'hFFFF_FFFF;
    rst_n = 1'b0; start = 0; stall = 0; br_taken = 0; dbg_req = 0;
    br_target = 0; dbg_addr = 0;
    #1;
    check_issue("rst", 32'd0, 6'd0, 1'b0, 16'd0);
    check_val("rst.halted", {31'd0, halted}, 32'd0);
    check_val("rst.ack", {31'd0, dbg_ack}, 32'd0);
    check_val("rst.ddata", dbg_data, 32'd0);
    check_val("rst.a", {26'd0, a}, 32'd0);
    tick; tick;
    rst_n = 1'b1;

    // Basic run into the halt word at address 3
    start = 1; tick; start = 0;
    check_val("start.a", {26'd0, a}, 32'd0);
    tick; check_issue("run0", 32'd11, 6'd0, 1'b1, 16'd1);
    tick; check_issue("run1", 32'd22, 6'd1, 1'b1, 16'd2);
    tick; check_issue("run2", 32'd33, 6'd2, 1'b1, 16'd3);
    tick; check_issue("halt", 32'd33, 6'd2, 1'b0, 16'd3);
    check_val("halt.halted", {31'd0, halted}, 32'd1);
    check_val("halt.a", {26'd0, a}, 32'd3);

    // Restart, then branch from PC=5 to 10
    mem[3] = 32'hA000_0003;
    start = 1; tick; start = 0;
    check_val("restart.halted", {31'd0, halted}, 32'd0);
    for (int i = 0; i < 5; i++) tick;
    check_issue("pre_br", 32'hA000_0004, 6'd4, 1'b1, 16'd8);
    check_val("pre_br.a", {26'd0, a}, 32'd5);
    br_taken = 1; br_target = 6'd10; tick; br_taken = 0;
    check_issue("br_sq", 32'hA000_0004, 6'd4, 1'b0, 16'd8);
    check_val("br_sq.a", {26'd0, a}, 32'd10);
    tick; check_issue("br_tgt", 32'hA000_000A, 6'd10, 1'b1, 16'd9);

    // Position at PC=7 with a live instruction, then stall with debug reads
    br_taken = 1; br_target = 6'd6; tick; br_taken = 0;
    tick; check_issue("at7", 32'hA000_0006, 6'd6, 1'b1, 16'd10);
    stall = 1; dbg_req = 1; dbg_addr = 6'd40;
    #1 check_val("dbg_grant.a", {26'd0, a}, 32'd40);
    tick;
    check_val("dbg1.ack", {31'd0, dbg_ack}, 32'd1);
    check_val("dbg1.data", dbg_data, 32'hA000_0028);
    check_val("dbg1.a", {26'd0, a}, 32'd7);
    check_issue("stall1", 32'hA000_0006, 6'd6, 1'b1, 16'd10);
    tick;
    check_val("dbg2.ack", {31'd0, dbg_ack}, 32'd0);
    check_issue("stall2", 32'hA000_0006, 6'd6, 1'b1, 16'd10);
    tick;
    check_val("dbg3.ack", {31'd0, dbg_ack}, 32'd1);
    check_val("dbg3.data", dbg_data, 32'hA000_0028);
    check_issue("stall3", 32'hA000_0006, 6'd6, 1'b1, 16'd10);
    stall = 0; dbg_req = 0;
    tick;
    check_val("dbg4.ack", {31'd0, dbg_ack}, 32'd0);
    check_issue("unstall", 32'hA000_0007, 6'd7, 1'b1, 16'd11);

    // Debug request while running unstalled: never granted
    dbg_req = 1; dbg_addr = 6'd40;
    #1 check_val("dbg_run.a", {26'd0, a}, 32'd8);
    tick;
    check_val("dbg_run1.ack", {31'd0, dbg_ack}, 32'd0);
    check_issue("dbg_run1", 32'hA000_0008, 6'd8, 1'b1, 16'd12);
    tick;
    check_val("dbg_run2.ack", {31'd0, dbg_ack}, 32'd0);
    check_issue("dbg_run2", 32'hA000_0009, 6'd9, 1'b1, 16'd13);
    dbg_req = 0;

    // Wrap across the end of memory
    br_taken = 1; br_target = 6'd62; tick; br_taken = 0;
    tick; check_issue("wrap62", 32'hA000_003E, 6'd62, 1'b1, 16'd14);
    tick; check_issue("wrap63", 32'hA000_003F, 6'd63, 1'b1, 16'd15);
    tick; check_issue("wrap0",  32'd11, 6'd0, 1'b1, 16'd16);
    tick; check_issue("wrap1",  32'd22, 6'd1, 1'b1, 16'd17);

    // Halt again, branch ignored in HALT, restart keeps the count
    mem[3] = 32'hFFFF_FFFF;
    tick; check_issue("h_run2", 32'd33, 6'd2, 1'b1, 16'd18);
    tick; check_val("h2.halted", {31'd0, halted}, 32'd1);
    br_taken = 1; br_target = 6'd20; tick; br_taken = 0;
    check_val("h2_br.a", {26'd0, a}, 32'd3);
    check_val("h2_br.halted", {31'd0, halted}, 32'd1);
    check_val("h2_br.valid", {31'd0, instr_valid}, 32'd0);
    start = 1; tick; start = 0;
    check_val("h2_st.a", {26'd0, a}, 32'd0);
    check_val("h2_st.halted", {31'd0, halted}, 32'd0);
    tick; check_issue("h2_st0", 32'd11, 6'd0, 1'b1, 16'd19);

    // Short asynchronous reset mid-run, then Start together with debug
    #2 rst_n = 1'b0;
    #1;
    check_issue("arst", 32'd0, 6'd0, 1'b0, 16'd0);
    check_val("arst.ddata", dbg_data, 32'd0);
    check_val("arst.a", {26'd0, a}, 32'd0);
    #2 rst_n = 1'b1;
    tick; check_issue("idle", 32'd0, 6'd0, 1'b0, 16'd0);
    start = 1; dbg_req = 1; dbg_addr = 6'd40;
    #1 check_val("st_dbg.a", {26'd0, a}, 32'd40);
    tick; start = 0; dbg_req = 0;
    check_val("st_dbg.ack", {31'd0, dbg_ack}, 32'd1);
    check_val("st_dbg.data", dbg_data, 32'hA000_0028);
    #1 check_val("st_dbg.pc", {26'd0, a}, 32'd0);
    tick; check_issue("rst_run0", 32'd11, 6'd0, 1'b1, 16'd1);
    check_val("rst_run0.ack", {31'd0, dbg_ack}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
